// File: rtl/rgb444_window3x3_gen.sv
// Raster RGB444 stream to one 3x3 neighbourhood word per pixel, using two line buffers.
// Optional macro BORDER_REPLICATE_EN: out-of-image neighbours replicate the nearest edge pixel instead of zero.
module rgb444_window3x3_gen #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [11:0]  pix_in,
  input  logic         pix_valid,
  input  logic         pix_sof,
  output logic         pix_ready,
  output logic [107:0] window_out,
  output logic         window_valid,
  output logic         window_sof,
  output logic         window_eof
);

  // Handshake: a pixel is taken on any clock edge where pix_valid && pix_ready;
  // window_valid is a single-cycle strobe with no backpressure.

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT + 3);
  localparam int FW = $clog2(IMG_WIDTH + 2);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [FW-1:0] F_LAST = FW'(IMG_WIDTH);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t state, state_nxt;

  logic          accept;
  logic          start;
  logic          advance;
  logic          trigger;
  logic          step;
  logic [XW-1:0] in_x;
  logic [YW-1:0] in_y;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic [FW-1:0] flush_cnt;
  logic [XW-1:0] wr_x;
  logic [11:0]   new_pix;
  logic [11:0]   rd1;
  logic [11:0]   rd2;

  logic [11:0] lb1 [IMG_WIDTH];
  logic [11:0] lb2 [IMG_WIDTH];

  // mid_* becomes the centre column at the next trigger, left_* the left column.
  logic [11:0] mid_t, mid_m, mid_b;
  logic [11:0] left_t, left_m, left_b;

  logic [11:0] w_c, w_l, w_r, w_u, w_d, w_ul, w_ur, w_dl, w_dr;
  logic        at_l, at_r, at_t, at_b;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = FILL;
      FILL: begin
        if (start) state_nxt = FILL;
        else if (advance && in_x == '0 && in_y == YW'(1)) state_nxt = RUN;
      end
      RUN: begin
        if (start) state_nxt = FILL;
        else if (advance && in_x == X_LAST && in_y == Y_LAST) state_nxt = FLUSH;
      end
      FLUSH: if (flush_cnt == F_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    pix_ready = (state != FLUSH);
    accept    = pix_valid && pix_ready;
    start     = accept && pix_sof;
    advance   = 1'b0;
    trigger   = 1'b0;
    case (state)
      FILL:  advance = accept && !pix_sof;
      RUN: begin
        advance = accept && !pix_sof;
        trigger = accept && !pix_sof;
      end
      FLUSH: begin
        advance = 1'b1;
        trigger = 1'b1;
      end
      default: ;
    endcase
  end

  assign step    = start || advance;
  assign wr_x    = start ? '0 : in_x;
  assign new_pix = (state == FLUSH) ? 12'h000 : pix_in;
  assign rd1     = lb1[wr_x];
  assign rd2     = lb2[wr_x];

  // Input position, centre position of the next window, and flush length
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_x      <= '0;
      in_y      <= '0;
      cx        <= '0;
      cy        <= '0;
      flush_cnt <= '0;
    end else begin
      if (start) begin
        in_x <= XW'(1);
        in_y <= '0;
      end else if (advance) begin
        if (in_x == X_LAST) begin
          in_x <= '0;
          in_y <= in_y + 1'b1;
        end else begin
          in_x <= in_x + 1'b1;
        end
      end
      if (start) begin
        cx <= '0;
        cy <= '0;
      end else if (trigger) begin
        if (cx == X_LAST) begin
          cx <= '0;
          cy <= cy + 1'b1;
        end else begin
          cx <= cx + 1'b1;
        end
      end
      flush_cnt <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
    end
  end

  // Line buffers and shift window carry only data, so they need no reset.
  always_ff @(posedge clk) begin
    if (step) begin
      lb1[wr_x] <= new_pix;
      lb2[wr_x] <= rd1;
      left_t    <= mid_t;
      left_m    <= mid_m;
      left_b    <= mid_b;
      mid_t     <= rd2;
      mid_m     <= rd1;
      mid_b     <= new_pix;
    end
  end

  assign at_l = (cx == '0);
  assign at_r = (cx == X_LAST);
  assign at_t = (cy == '0);
  assign at_b = (cy == Y_LAST);

  // Borders come from the centre counters, never from stale line-buffer data.
  always_comb begin
    w_c  = mid_m;
    w_l  = left_m;
    w_r  = rd1;
    w_u  = mid_t;
    w_d  = mid_b;
    w_ul = left_t;
    w_ur = rd2;
    w_dl = left_b;
    w_dr = new_pix;
`ifdef BORDER_REPLICATE_EN
    if (at_l) begin
      w_ul = w_u;
      w_l  = w_c;
      w_dl = w_d;
    end
    if (at_r) begin
      w_ur = w_u;
      w_r  = w_c;
      w_dr = w_d;
    end
    if (at_t) begin
      w_ul = w_l;
      w_u  = w_c;
      w_ur = w_r;
    end
    if (at_b) begin
      w_dl = w_l;
      w_d  = w_c;
      w_dr = w_r;
    end
`else
    if (at_l) begin
      w_ul = 12'h000;
      w_l  = 12'h000;
      w_dl = 12'h000;
    end
    if (at_r) begin
      w_ur = 12'h000;
      w_r  = 12'h000;
      w_dr = 12'h000;
    end
    if (at_t) begin
      w_ul = 12'h000;
      w_u  = 12'h000;
      w_ur = 12'h000;
    end
    if (at_b) begin
      w_dl = 12'h000;
      w_d  = 12'h000;
      w_dr = 12'h000;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      window_out   <= '0;
      window_valid <= 1'b0;
      window_sof   <= 1'b0;
      window_eof   <= 1'b0;
    end else begin
      window_valid <= trigger;
      window_sof   <= trigger && at_l && at_t;
      window_eof   <= trigger && at_r && at_b;
      if (trigger) window_out <= {w_c, w_l, w_r, w_u, w_d, w_ul, w_ur, w_dl, w_dr};
    end
  end

endmodule

// File: tb/tb_rgb444_window3x3_gen.sv
// Directed bench for rgb444_window3x3_gen on a 4x3 image; honours BORDER_REPLICATE_EN.
module tb_rgb444_window3x3_gen;

  localparam int W = 4;
  localparam int H = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [11:0]  pix_in;
  logic         pix_valid;
  logic         pix_sof;
  logic         pix_ready;
  logic [107:0] window_out;
  logic         window_valid;
  logic         window_sof;
  logic         window_eof;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Entries are {eof, sof, window}.
  logic [109:0] got_q[$];
  logic [109:0] exp_q[$];

  rgb444_window3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk          (clk),
    .reset        (reset),
    .pix_in       (pix_in),
    .pix_valid    (pix_valid),
    .pix_sof      (pix_sof),
    .pix_ready    (pix_ready),
    .window_out   (window_out),
    .window_valid (window_valid),
    .window_sof   (window_sof),
    .window_eof   (window_eof)
  );

  // Clock and monitor
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (window_valid) got_q.push_back({window_eof, window_sof, window_out});
  end

  function automatic logic [11:0] pix(input int x, input int y);
    logic [3:0] xs, ys;
    xs = 4'(x);
    ys = 4'(y);
    return {4'h1, ys, xs};
  endfunction

  function automatic logic [11:0] nb(input int x, input int y);
    int xc, yc;
    if (x >= 0 && x < W && y >= 0 && y < H) return pix(x, y);
`ifdef BORDER_REPLICATE_EN
    xc = (x < 0) ? 0 : (x >= W) ? W - 1 : x;
    yc = (y < 0) ? 0 : (y >= H) ? H - 1 : y;
    return pix(xc, yc);
`else
    xc = 0;
    yc = 0;
    return 12'h000 | 12'(xc + yc);
`endif
  endfunction

  function automatic logic [107:0] exp_win(input int cx, input int cy);
    return {nb(cx, cy), nb(cx - 1, cy), nb(cx + 1, cy), nb(cx, cy - 1), nb(cx, cy + 1),
            nb(cx - 1, cy - 1), nb(cx + 1, cy - 1), nb(cx - 1, cy + 1), nb(cx + 1, cy + 1)};
  endfunction

  function automatic logic [109:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return '0;
  endfunction

  task automatic check(input string tag, input logic [109:0] obs, input logic [109:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Driver tasks
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int x, input int y, input logic sof);
    int guard;
    guard = 0;
    while (!pix_ready && guard < 50) begin
      cycles(1);
      guard++;
    end
    if (guard >= 50) check("ready_timeout", 110'(pix_ready), 110'(1));
    pix_in    = pix(x, y);
    pix_valid = 1'b1;
    pix_sof   = sof;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_in    = 12'h000;
  endtask

  task automatic send_frame(input logic gap);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        send(x, y, x == 0 && y == 0);
        if (gap) cycles(1);
      end
    end
  endtask

  task automatic push_frame();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back({(x == W - 1 && y == H - 1), (x == 0 && y == 0), exp_win(x, y)});
  endtask

  task automatic compare_q(input string tag);
    check({tag, "_count"}, 110'(got_q.size()), 110'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), got_at(i), exp_q[i]);
  endtask

  task automatic clear_q();
    got_q.delete();
    exp_q.delete();
  endtask

  logic [107:0] lit_center = {12'h111, 12'h110, 12'h112, 12'h101, 12'h121,
                              12'h100, 12'h102, 12'h120, 12'h122};
`ifdef BORDER_REPLICATE_EN
  logic [107:0] lit_corner = {12'h100, 12'h100, 12'h101, 12'h100, 12'h110,
                              12'h100, 12'h101, 12'h110, 12'h111};
  logic [107:0] lit_last   = {12'h123, 12'h122, 12'h123, 12'h113, 12'h123,
                              12'h112, 12'h113, 12'h122, 12'h123};
`else
  logic [107:0] lit_corner = {12'h100, 12'h000, 12'h101, 12'h000, 12'h110,
                              12'h000, 12'h000, 12'h000, 12'h111};
  logic [107:0] lit_last   = {12'h123, 12'h122, 12'h000, 12'h113, 12'h000,
                              12'h112, 12'h000, 12'h000, 12'h000};
`endif

  initial begin
    int k, low_cnt, n0;
    logic [109:0] e;
    reset = 1'b1;
    pix_in = 12'h000;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    cycles(3);

    // Reset state
    check("rst_valid", 110'(window_valid), 110'(0));
    check("rst_ready", 110'(pix_ready), 110'(1));
    check("rst_window", 110'(window_out), 110'(0));
    check("rst_flags", 110'({window_sof, window_eof}), 110'(0));
    reset = 1'b0;
    cycles(2);

    // Continuous frame, first-window latency and flush length
    clear_q();
    k = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        send(x, y, x == 0 && y == 0);
        k++;
        if (k == 5) check("no_win_after_5", 110'(window_valid), 110'(0));
        if (k == 6) check("first_win_after_6", 110'({window_valid, window_sof}), 110'(2'b11));
      end
    end
    n0 = got_q.size();
    low_cnt = 0;
    while (!pix_ready && low_cnt < 20) begin
      low_cnt++;
      cycles(1);
    end
    check("flush_ready_low", 110'(low_cnt), 110'(5));
    cycles(4);
    check("flush_windows", 110'(got_q.size() - n0 - 1), 110'(5));
    push_frame();
    compare_q("frame1");
    e = got_at(5);
    check("center_1_1", 110'(e[107:0]), 110'(lit_center));
    e = got_at(0);
    check("corner_0_0", 110'(e[107:0]), 110'(lit_corner));
    e = got_at(11);
    check("last_eof", 110'({e[109], e[107:0]}), 110'({1'b1, lit_last}));

    // pix_valid toggling gives the same windows
    clear_q();
    send_frame(1'b1);
    cycles(10);
    push_frame();
    compare_q("toggle");

    // Abort with pix_sof on the 7th pixel
    clear_q();
    for (int i = 0; i < 6; i++) send(i % W, i / W, i == 0);
    send_frame(1'b0);
    cycles(10);
    exp_q.push_back({1'b0, 1'b1, exp_win(0, 0)});
    push_frame();
    compare_q("abort");

    // Reset in the third flush cycle
    send_frame(1'b0);
    cycles(2);
    check("flush3_ready", 110'(pix_ready), 110'(0));
    reset = 1'b1;
    #1;
    check("mid_flush_rst_valid", 110'(window_valid), 110'(0));
    check("mid_flush_rst_ready", 110'(pix_ready), 110'(1));
    cycles(2);
    reset = 1'b0;
    cycles(2);
    clear_q();
    send_frame(1'b0);
    cycles(10);
    push_frame();
    compare_q("after_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
